veri_yazma_tamponu: RTL and testbench

Store buffer between the memory-access unit (bellek_islem_birimi) and the data-memory bus. It absorbs stores in a small FIFO so the execute stage does not wait on the bus, drains them in program order, and serves loads either by forwarding from a fully written buffered word or by a single outstanding bus read. Load data is returned on the cycle after the request is accepted, which matches the unit's registered load-format select.

---
 rtl/veri_yazma_tamponu_pkg.sv | 23 ++
 rtl/veri_yazma_tamponu_yazma_fifo.sv | 76 +++++++
 rtl/veri_yazma_tamponu.sv | 173 +++++++++++++++++
 tb/tb_veri_yazma_tamponu.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/veri_yazma_tamponu_pkg.sv
// Shared types for the store buffer: FSM state encodings and FIFO entry layout.
package veri_yazma_tamponu_pkg;

    localparam int ADR_W   = 30;  // word address, byte offset dropped
    localparam int VERI_W  = 32;
    localparam int MASKE_W = 4;

    localparam logic [MASKE_W-1:0] TAM_MASKE = '1;

    typedef enum logic [1:0] {
        BOSTA     = 2'd0,
        OKU_ISTEK = 2'd1,
        OKU_BEKLE = 2'd2,
        YAZ_ISTEK = 2'd3
    } durum_e;

    typedef struct packed {
        logic [ADR_W-1:0]   adr;
        logic [VERI_W-1:0]  veri;
        logic [MASKE_W-1:0] maske;
    } girdi_t;

endpackage

// File: rtl/veri_yazma_tamponu_yazma_fifo.sv
// Circular store FIFO with head/tail pointers carrying a wrap bit.
// Every entry is exposed so the parent can do address matching.
module veri_yazma_tamponu_yazma_fifo
    import veri_yazma_tamponu_pkg::*;
#(
    parameter int DERINLIK = 4,
    localparam int PW = $clog2(DERINLIK)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ekle_i,
    input  girdi_t            ekle_girdi_i,
    input  logic              cikar_i,
    output logic              dolu_o,
    output logic              bos_o,
    output logic [DERINLIK-1:0] gecerli_o,
    output girdi_t            girdiler_o [DERINLIK],
    output girdi_t            bas_o,
    output logic [PW-1:0]     bas_ptr_o
);

    logic [PW:0] bas_q, bas_d;
    logic [PW:0] kuyruk_q, kuyruk_d;
    logic [PW:0] sayi;
    girdi_t      mem_q [DERINLIK];
    girdi_t      mem_d [DERINLIK];

    assign sayi      = kuyruk_q - bas_q;
    assign bos_o     = (bas_q == kuyruk_q);
    assign dolu_o    = (bas_q[PW] != kuyruk_q[PW]) && (bas_q[PW-1:0] == kuyruk_q[PW-1:0]);
    assign bas_o     = mem_q[bas_q[PW-1:0]];
    assign bas_ptr_o = bas_q[PW-1:0];
    assign girdiler_o = mem_q;

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        logic [PW-1:0] ofs;
        ofs       = '0;
        gecerli_o = '0;
        for (int i = 0; i < DERINLIK; i++) begin
            ofs          = PW'(i) - bas_q[PW-1:0];
            gecerli_o[i] = ({1'b0, ofs} < sayi);
        end
    end

    // Pointer advance and storage write for enqueue/dequeue.
    always_comb begin
        bas_d    = bas_q;
        kuyruk_d = kuyruk_q;
        mem_d    = mem_q;
        if (ekle_i && !dolu_o) begin
            mem_d[kuyruk_q[PW-1:0]] = ekle_girdi_i;
            kuyruk_d                = kuyruk_q + 1'b1;
        end
        if (cikar_i && !bos_o) begin
            bas_d = bas_q + 1'b1;
        end
    end

    // Pointers reset to empty; stored stores are discarded by that.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bas_q    <= '0;
            kuyruk_q <= '0;
        end else begin
            bas_q    <= bas_d;
            kuyruk_q <= kuyruk_d;
        end
    end

    // Entry storage needs no reset: validity comes from the pointers.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/veri_yazma_tamponu.sv
// Store buffer between the memory-access unit and the data bus: buffers
// stores, drains them in order, forwards full-word hits to loads and
// otherwise issues a single outstanding bus read.
module veri_yazma_tamponu
    import veri_yazma_tamponu_pkg::*;
#(
    parameter int DERINLIK = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        l1v_sec_n_i,
    input  logic        l1v_yaz_gecerli_i,
    input  logic [31:0] l1v_adr_i,
    input  logic [31:0] l1v_veri_i,
    input  logic [3:0]  l1v_veri_maske_i,
    output logic [31:0] l1v_veri_o,
    output logic        l1v_durdur_o,
    output logic        bos_o,
    output logic        bellek_istek_gecerli_o,
    input  logic        bellek_istek_hazir_i,
    output logic        bellek_yaz_o,
    output logic [31:0] bellek_adr_o,
    output logic [31:0] bellek_veri_o,
    output logic [3:0]  bellek_maske_o,
    input  logic        bellek_cevap_gecerli_i,
    input  logic [31:0] bellek_veri_i
);

    localparam int PW = $clog2(DERINLIK);

    durum_e              durum_q, durum_d;
    logic [ADR_W-1:0]    oku_adr_q, oku_adr_d;
    logic [31:0]         l1v_veri_q, l1v_veri_d;

    logic                istek, yaz_istek, yukle;
    logic                ekle, cikar;
    logic                fifo_dolu, fifo_bos;
    logic [DERINLIK-1:0] gecerli;
    girdi_t              girdiler [DERINLIK];
    girdi_t              bas;
    logic [PW-1:0]       bas_ptr;
    girdi_t              yeni_girdi;
    logic                eslesme, ileri, oku_bekliyor, cevap_alindi;
    girdi_t              genc;
    logic [1:0]          unused_adr_bitleri;

    assign istek     = !l1v_sec_n_i;
    assign yaz_istek = istek && l1v_yaz_gecerli_i;
    assign yukle     = istek && !l1v_yaz_gecerli_i;
    assign ekle      = yaz_istek && !fifo_dolu;
    assign cikar     = (durum_q == YAZ_ISTEK) && bellek_istek_hazir_i;
    assign unused_adr_bitleri = l1v_adr_i[1:0];

    assign yeni_girdi = '{adr: l1v_adr_i[31:2], veri: l1v_veri_i, maske: l1v_veri_maske_i};

    veri_yazma_tamponu_yazma_fifo #(
        .DERINLIK (DERINLIK)
    ) u_yazma_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ekle_i       (ekle),
        .ekle_girdi_i (yeni_girdi),
        .cikar_i      (cikar),
        .dolu_o       (fifo_dolu),
        .bos_o        (fifo_bos),
        .gecerli_o    (gecerli),
        .girdiler_o   (girdiler),
        .bas_o        (bas),
        .bas_ptr_o    (bas_ptr)
    );

    // Walk from oldest to youngest so the last hit is the youngest match.
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        eslesme = 1'b0;
        genc    = '0;
        for (int k = 0; k < DERINLIK; k++) begin
            idx = bas_ptr + PW'(k);
            if (gecerli[idx] && (girdiler[idx].adr == l1v_adr_i[31:2])) begin
                eslesme = 1'b1;
                genc    = girdiler[idx];
            end
        end
    end

    assign ileri        = yukle && eslesme && (genc.maske == TAM_MASKE);
    assign oku_bekliyor = yukle && !eslesme;
    assign cevap_alindi = (durum_q == OKU_BEKLE) && bellek_cevap_gecerli_i;

    // Stall: stores wait on a full FIFO, loads wait unless served this cycle.
    always_comb begin
        l1v_durdur_o = 1'b0;
        if (yaz_istek) begin
            l1v_durdur_o = fifo_dolu;
        end else if (yukle) begin
            l1v_durdur_o = !(ileri || cevap_alindi);
        end
    end

    // Bus FSM next state plus load-data capture; a waiting load beats a drain.
    always_comb begin
        durum_d    = durum_q;
        oku_adr_d  = oku_adr_q;
        l1v_veri_d = l1v_veri_q;
        case (durum_q)
            BOSTA: begin
                if (oku_bekliyor) begin
                    durum_d   = OKU_ISTEK;
                    oku_adr_d = l1v_adr_i[31:2];
                end else if (!fifo_bos || ekle) begin
                    durum_d = YAZ_ISTEK;
                end
            end
            OKU_ISTEK: begin
                if (bellek_istek_hazir_i) durum_d = OKU_BEKLE;
            end
            OKU_BEKLE: begin
                if (bellek_cevap_gecerli_i) begin
                    durum_d    = BOSTA;
                    l1v_veri_d = bellek_veri_i;
                end
            end
            YAZ_ISTEK: begin
                if (bellek_istek_hazir_i) durum_d = BOSTA;
            end
            default: durum_d = BOSTA;
        endcase
        if (ileri) begin
            l1v_veri_d = genc.veri;
        end
    end

    // Bus request fields come from registered state, so they hold while stalled.
    always_comb begin
        bellek_istek_gecerli_o = 1'b0;
        bellek_yaz_o           = 1'b0;
        bellek_adr_o           = '0;
        bellek_veri_o          = '0;
        bellek_maske_o         = '0;
        case (durum_q)
            OKU_ISTEK: begin
                bellek_istek_gecerli_o = 1'b1;
                bellek_adr_o           = {oku_adr_q, 2'b00};
            end
            YAZ_ISTEK: begin
                bellek_istek_gecerli_o = 1'b1;
                bellek_yaz_o           = 1'b1;
                bellek_adr_o           = {bas.adr, 2'b00};
                bellek_veri_o          = bas.veri;
                bellek_maske_o         = bas.maske;
            end
            default: ;
        endcase
    end

    assign bos_o      = fifo_bos && (durum_q != OKU_ISTEK) && (durum_q != OKU_BEKLE);
    assign l1v_veri_o = l1v_veri_q;

    // State, latched read address and returned load data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_q    <= BOSTA;
            oku_adr_q  <= '0;
            l1v_veri_q <= '0;
        end else begin
            durum_q    <= durum_d;
            oku_adr_q  <= oku_adr_d;
            l1v_veri_q <= l1v_veri_d;
        end
    end

endmodule

// File: tb/tb_veri_yazma_tamponu.sv
// Scoreboard bench for the store buffer: stimulus pushes expected bus
// transactions and load data; a monitor pops and compares them.
module tb_veri_yazma_tamponu;

    typedef struct {
        logic        yaz;
        logic [31:0] adr;
        logic [31:0] veri;
        logic [3:0]  maske;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sec_n, yaz_g;
    logic [31:0] adr, veri;
    logic [3:0]  maske;
    logic [31:0] l1v_veri_o;
    logic        durdur, bos;
    logic        gecerli, hazir, yaz, cevap;
    logic [31:0] b_adr, b_veri, b_cevap_veri;
    logic [3:0]  b_maske;

    int checks = 0;
    int errors = 0;

    bus_t        bus_q [$];
    logic [31:0] yuk_q [$];

    int hazir_gecikme = 0;
    int cevap_gecikme = 0;
    bit hazir_kapali  = 0;

    always #5 clk = ~clk;

    veri_yazma_tamponu #(.DERINLIK(4)) dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_n),
        .l1v_sec_n_i            (sec_n),
        .l1v_yaz_gecerli_i      (yaz_g),
        .l1v_adr_i              (adr),
        .l1v_veri_i             (veri),
        .l1v_veri_maske_i       (maske),
        .l1v_veri_o             (l1v_veri_o),
        .l1v_durdur_o           (durdur),
        .bos_o                  (bos),
        .bellek_istek_gecerli_o (gecerli),
        .bellek_istek_hazir_i   (hazir),
        .bellek_yaz_o           (yaz),
        .bellek_adr_o           (b_adr),
        .bellek_veri_o          (b_veri),
        .bellek_maske_o         (b_maske),
        .bellek_cevap_gecerli_i (cevap),
        .bellek_veri_i          (b_cevap_veri)
    );

    task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        checks++;
        if (gercek !== beklenen) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", ad, gercek, beklenen, $time);
        end
    endtask

    // Bus responder: hazir after a programmable wait, read data after another.
    initial begin
        int bekleme = 0;
        int oku_sayac = 0;
        logic [31:0] oku_adr = '0;
        hazir = 1'b0; cevap = 1'b0; b_cevap_veri = '0;
        forever begin
            @(posedge clk); #2;
            hazir = 1'b0;
            cevap = 1'b0;
            if (oku_sayac > 0) begin
                oku_sayac--;
                if (oku_sayac == 0) begin
                    cevap        = 1'b1;
                    b_cevap_veri = oku_adr ^ 32'hC0DE_0000;
                end
            end else if (gecerli && !hazir_kapali) begin
                if (bekleme < hazir_gecikme) begin
                    bekleme++;
                end else begin
                    hazir   = 1'b1;
                    bekleme = 0;
                    if (!yaz) begin
                        oku_sayac = cevap_gecikme + 1;
                        oku_adr   = b_adr;
                    end
                end
            end
        end
    end

    // Monitor: compares bus handshakes and returned load data against the queues.
    bit yuk_bekle = 0;
    always @(negedge clk) begin
        if (yuk_bekle) begin
            if (yuk_q.size() == 0) begin
                kontrol("yuk_beklenmeyen", l1v_veri_o, 32'hxxxx_xxxx);
            end else begin
                kontrol("yuk_veri", l1v_veri_o, yuk_q.pop_front());
            end
        end
        yuk_bekle = rst_n && !sec_n && !yaz_g && !durdur;
        if (rst_n && gecerli && hazir) begin
            if (bus_q.size() == 0) begin
                kontrol("bus_beklenmeyen", b_adr, 32'hxxxx_xxxx);
            end else begin
                bus_t e;
                e = bus_q.pop_front();
                kontrol("bus_yaz", {31'b0, yaz}, {31'b0, e.yaz});
                kontrol("bus_adr", b_adr, e.adr);
                if (e.yaz) begin
                    kontrol("bus_veri", b_veri, e.veri);
                    kontrol("bus_maske", {28'b0, b_maske}, {28'b0, e.maske});
                end
            end
        end
    end

    // One request held until accepted; returns the number of stalled cycles.
    task automatic istek(input logic y, input logic [31:0] a, input logic [31:0] v,
                         input logic [3:0] m, output int durus);
        bit kabul;
        kabul = 0;
        durus = 0;
        sec_n = 1'b0; yaz_g = y; adr = a; veri = v; maske = m;
        for (int i = 0; i < 100 && !kabul; i++) begin
            @(negedge clk);
            if (!durdur) kabul = 1;
            else durus++;
        end
        if (!kabul) begin
            checks++; errors++;
            $display("FAIL istek_zaman_asimi adr=%h durus=%0d want accept", a, durus);
        end
        @(posedge clk); #1;
        sec_n = 1'b1; yaz_g = 1'b0;
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] v, input logic [3:0] m);
        int d;
        istek(1'b1, a, v, m, d);
    endtask

    task automatic bus_bekle(input logic y, input logic [31:0] a, input logic [31:0] v, input logic [3:0] m);
        bus_t e;
        e.yaz = y; e.adr = a; e.veri = v; e.maske = m;
        bus_q.push_back(e);
    endtask

    task automatic bosalt();
        bit bitti;
        bitti = 0;
        for (int i = 0; i < 300 && !bitti; i++) begin
            @(negedge clk);
            if (bos) bitti = 1;
        end
        if (!bitti) begin
            checks++; errors++;
            $display("FAIL bosalt_zaman_asimi bos=%0b want 1", bos);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int d;
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d;
        rst_n = 1'b0; sec_n = 1'b1; yaz_g = 1'b0;
        adr = '0; veri = '0; maske = '0;
        repeat (2) @(posedge clk);
        #1;
        kontrol("rst_veri",    l1v_veri_o, 32'h0);
        kontrol("rst_durdur",  {31'b0, durdur},  32'h0);
        kontrol("rst_gecerli", {31'b0, gecerli}, 32'h0);
        kontrol("rst_yaz",     {31'b0, yaz},     32'h0);
        kontrol("rst_bos",     {31'b0, bos},     32'h1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-word store then load: forwarded with no stall and no bus read.
        bus_bekle(1'b1, 32'h100, 32'hDEADBEEF, 4'b1111);
        yuk_q.push_back(32'hDEADBEEF);
        sw(32'h100, 32'hDEADBEEF, 4'b1111);
        istek(1'b0, 32'h100, 32'h0, 4'h0, d);
        kontrol("ileri_durus", 32'(d), 32'd0);
        bosalt();

        // Partial store then load: stall until the write drains, then bus read.
        bus_bekle(1'b1, 32'h200, 32'h0000_00AB, 4'b0001);
        bus_bekle(1'b0, 32'h200, 32'h0, 4'h0);
        yuk_q.push_back(32'hC0DE_0200);
        sw(32'h200, 32'h0000_00AB, 4'b0001);
        istek(1'b0, 32'h200, 32'h0, 4'h0, d);
        kontrol("kismi_durus", 32'(d), 32'd3);
        bosalt();

        // Five stores against a stalled bus: the fifth waits for the first drain.
        hazir_kapali = 1;
        for (int i = 0; i < 5; i++) begin
            bus_bekle(1'b1, 32'h600 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'b1111);
        end
        for (int i = 0; i < 4; i++) begin
            sw(32'h600 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'b1111);
        end
        fork
            istek(1'b1, 32'h610, 32'hA000_0004, 4'b1111, d);
            begin
                repeat (3) @(posedge clk);
                #1;
                hazir_kapali = 0;
            end
        join
        kontrol("dolu_durus", 32'(d), 32'd4);
        bosalt();

        // Non-matching load overtakes buffered stores; slow bus on both phases.
        hazir_gecikme = 3;
        cevap_gecikme = 3;
        bus_bekle(1'b1, 32'h2F0, 32'h0000_02F0, 4'b1111);
        bus_bekle(1'b0, 32'h400, 32'h0, 4'h0);
        bus_bekle(1'b1, 32'h300, 32'h0000_0300, 4'b1111);
        bus_bekle(1'b1, 32'h304, 32'h0000_0304, 4'b1111);
        yuk_q.push_back(32'hC0DE_0400);
        sw(32'h2F0, 32'h0000_02F0, 4'b1111);
        sw(32'h300, 32'h0000_0300, 4'b1111);
        sw(32'h304, 32'h0000_0304, 4'b1111);
        istek(1'b0, 32'h400, 32'h0, 4'h0, d);
        kontrol("oku_durus", 32'(d), 32'd10);
        bosalt();
        hazir_gecikme = 0;
        cevap_gecikme = 0;

        // Two stores to one word: the youngest is forwarded.
        hazir_kapali = 1;
        bus_bekle(1'b1, 32'h500, 32'h1111_1111, 4'b1111);
        bus_bekle(1'b1, 32'h500, 32'h2222_2222, 4'b1111);
        yuk_q.push_back(32'h2222_2222);
        sw(32'h500, 32'h1111_1111, 4'b1111);
        sw(32'h500, 32'h2222_2222, 4'b1111);
        istek(1'b0, 32'h500, 32'h0, 4'h0, d);
        kontrol("genc_durus", 32'(d), 32'd0);
        hazir_kapali = 0;
        bosalt();

        // Reset while a read is outstanding with three stores still buffered.
        cevap_gecikme = 20;
        hazir_kapali  = 1;
        bus_bekle(1'b1, 32'h6F0, 32'h0000_06F0, 4'b1111);
        bus_bekle(1'b0, 32'h800, 32'h0, 4'h0);
        sw(32'h6F0, 32'h0000_06F0, 4'b1111);
        sw(32'h700, 32'h0000_0700, 4'b1111);
        sw(32'h704, 32'h0000_0704, 4'b1111);
        sw(32'h708, 32'h0000_0708, 4'b1111);
        sec_n = 1'b0; yaz_g = 1'b0; adr = 32'h800;
        hazir_kapali = 0;
        repeat (4) @(posedge clk);
        #1;
        kontrol("oku_bekle_bos", {31'b0, bos}, 32'h0);
        rst_n = 1'b0;
        sec_n = 1'b1;
        #1;
        kontrol("arst_veri",    l1v_veri_o, 32'h0);
        kontrol("arst_durdur",  {31'b0, durdur},  32'h0);
        kontrol("arst_gecerli", {31'b0, gecerli}, 32'h0);
        kontrol("arst_yaz",     {31'b0, yaz},     32'h0);
        kontrol("arst_bos",     {31'b0, bos},     32'h1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        begin
            bit goruldu;
            goruldu = 0;
            for (int i = 0; i < 60 && !goruldu; i++) begin
                @(negedge clk);
                if (cevap) goruldu = 1;
            end
            kontrol("gec_cevap_geldi", {31'b0, goruldu}, 32'h1);
        end
        @(negedge clk);
        kontrol("gec_cevap_veri",    l1v_veri_o, 32'h0);
        kontrol("gec_cevap_bos",     {31'b0, bos}, 32'h1);
        kontrol("gec_cevap_gecerli", {31'b0, gecerli}, 32'h0);
        repeat (5) @(negedge clk);
        kontrol("son_bus_kuyruk", 32'(bus_q.size()), 32'd0);
        kontrol("son_yuk_kuyruk", 32'(yuk_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
